// File: rtl/rpn_sequencer.sv
// rpn_sequencer: steps through a 256-word program, feeding PUSH and OP
// instructions to an external stack calculator one per cycle. On HALT, or
// after running off the end of memory, it captures the calculator's
// top-of-stack value.
module rpn_sequencer (
    input  logic        step,
    input  logic        nrst,
    input  logic        prog_we,
    input  logic [7:0]  prog_addr,
    input  logic [17:0] prog_data,
    input  logic        start,
    input  logic [15:0] calc_out,
    input  logic [9:0]  calc_cnt,
    output logic        push,
    output logic [1:0]  op,
    output logic [15:0] d,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] result,
    output logic [7:0]  pc
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

    localparam logic [1:0] K_PUSH = 2'b00;
    localparam logic [1:0] K_OP   = 2'b01;
    localparam logic [1:0] K_HALT = 2'b11;

    state_t       state_reg;
    logic [7:0]   pc_reg;
    logic [15:0]  result_reg;
    logic         eom_latch_reg;   // end-of-memory: capture result on next edge
    logic [17:0]  prog_mem [0:255];

    logic [17:0]  instr;
    logic [1:0]   kind;
    logic [15:0]  payload;
    logic         underflow;
    logic         push_next;
    logic [1:0]   op_next;
    logic [15:0]  d_next;

    // Program store: writable only while no program is executing; not reset
    always_ff @(posedge step) begin
        if (prog_we && (state_reg != S_RUN))
            prog_mem[prog_addr] <= prog_data;
    end

    assign instr     = prog_mem[pc_reg];
    assign kind      = instr[17:16];
    assign payload   = instr[15:0];
    // Binary ops need operands; an empty stack aborts before issuing
    assign underflow = (kind == K_OP) && payload[1] && (calc_cnt == 10'd0);

    // Zero-latency issue: the calculator sees the current instruction this cycle
    always_comb begin
        push_next = 1'b0;
        op_next   = 2'b00;
        d_next    = 16'h0000;
        if ((state_reg == S_RUN) && !underflow) begin
            case (kind)
                K_PUSH: begin
                    push_next = 1'b1;
                    d_next    = payload;
                end
                K_OP:    op_next = payload[1:0];
                default: ;
            endcase
        end
    end

    // Control FSM: program counter, result capture and status
    always_ff @(posedge step or negedge nrst) begin
        if (!nrst) begin
            state_reg     <= S_IDLE;
            pc_reg        <= 8'd0;
            result_reg    <= 16'h0000;
            eom_latch_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_RUN: begin
                    if (underflow) begin
                        state_reg <= S_ERR;
                    end else if (kind == K_HALT) begin
                        result_reg <= calc_out;
                        state_reg  <= S_DONE;
                    end else if (pc_reg == 8'd255) begin
                        // Last word executed; calculator output settles next cycle
                        state_reg     <= S_DONE;
                        eom_latch_reg <= 1'b1;
                    end else begin
                        pc_reg <= pc_reg + 8'd1;
                    end
                end
                default: begin
                    if (eom_latch_reg) begin
                        result_reg    <= calc_out;
                        eom_latch_reg <= 1'b0;
                    end
                    if (start) begin
                        state_reg <= S_RUN;
                        pc_reg    <= 8'd0;
                    end
                end
            endcase
        end
    end

    assign push   = push_next;
    assign op     = op_next;
    assign d      = d_next;
    assign busy   = (state_reg == S_RUN);
    assign done   = (state_reg == S_DONE);
    assign err    = (state_reg == S_ERR);
    assign result = result_reg;
    assign pc     = pc_reg;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Directed bench: rpn_sequencer driving a small behavioral stack calculator.
module tb_rpn_sequencer;

    logic        step = 1'b0;
    logic        nrst = 1'b0;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = 8'd0;
    logic [17:0] prog_data = 18'd0;
    logic        start = 1'b0;
    logic [15:0] calc_out;
    logic [9:0]  calc_cnt;
    logic        push;
    logic [1:0]  op;
    logic [15:0] d;
    logic        busy, done, err;
    logic [15:0] result;
    logic [7:0]  pc;

    int checks = 0;
    int errors = 0;

    rpn_sequencer dut (
        .step(step), .nrst(nrst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .calc_out(calc_out),
        .calc_cnt(calc_cnt), .push(push), .op(op), .d(d), .busy(busy),
        .done(done), .err(err), .result(result), .pc(pc)
    );

    always #5 step = ~step;

    // Stack calculator model
    logic [15:0] stk [0:1023];
    logic [9:0]  cnt;
    always @(posedge step or negedge nrst) begin
        if (!nrst) begin
            cnt <= 10'd0;
        end else if (push) begin
            stk[cnt] <= d;
            cnt      <= cnt + 10'd1;
        end else begin
            case (op)
                2'b01: if (cnt != 0) stk[cnt-1] <= 16'h0000 - stk[cnt-1];
                2'b10: if (cnt >= 2) begin
                    stk[cnt-2] <= stk[cnt-2] + stk[cnt-1];
                    cnt        <= cnt - 10'd1;
                end
                2'b11: if (cnt >= 2) begin
                    stk[cnt-2] <= stk[cnt-2] * stk[cnt-1];
                    cnt        <= cnt - 10'd1;
                end
                default: ;
            endcase
        end
    end
    assign calc_out = (cnt == 0) ? 16'h0000 : stk[cnt-1];
    assign calc_cnt = cnt;

    localparam logic [17:0] I_ADD  = {2'b01, 16'd2};
    localparam logic [17:0] I_NEG  = {2'b01, 16'd1};
    localparam logic [17:0] I_MUL  = {2'b01, 16'd3};
    localparam logic [17:0] I_NOP  = {2'b10, 16'd0};
    localparam logic [17:0] I_HALT = {2'b11, 16'd0};

    function automatic logic [17:0] i_push(input logic [15:0] v);
        return {2'b00, v};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) begin
            $display("check %s ok got=%0h", tag, got);
        end else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [17:0] w);
        @(negedge step);
        prog_we = 1'b1; prog_addr = a; prog_data = w;
        @(negedge step);
        prog_we = 1'b0;
    endtask

    task automatic do_start();
        @(negedge step);
        start = 1'b1;
        @(negedge step);
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge step);
        nrst = 1'b0;
        @(negedge step);
        nrst = 1'b1;
    endtask

    task automatic wait_end(input int max_cycles);
        int n = 0;
        while (!done && !err && n < max_cycles) begin
            @(negedge step);
            n++;
        end
        chk("wait_end", {31'd0, done | err}, 32'd1);
    endtask

    task automatic load_add34();
        wr(8'd0, i_push(16'd3));
        wr(8'd1, i_push(16'd4));
        wr(8'd2, I_ADD);
        wr(8'd3, I_HALT);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_outs", {busy, done, err, push, op, d, result, pc}, 32'd0);
        do_reset();

        // PUSH 3, PUSH 4, ADD, HALT: cycle-by-cycle issue
        load_add34();
        do_start();
        chk("a_c1", {busy, push, op, d}, {1'b1, 1'b1, 2'b00, 16'd3});
        chk("a_pc0", pc, 0);
        @(negedge step);
        chk("a_c2", {push, op, d}, {1'b1, 2'b00, 16'd4});
        @(negedge step);
        chk("a_c3", {push, op, d}, {1'b0, 2'b10, 16'd0});
        @(negedge step);
        chk("a_c4", {busy, done, push, op, d}, {1'b1, 1'b0, 1'b0, 2'b00, 16'd0});
        @(negedge step);
        chk("a_done", {busy, done, err}, 3'b010);
        chk("a_result", result, 16'd7);
        chk("a_pc_hold", pc, 3);

        // PUSH 5, NEG, HALT
        do_reset();
        wr(8'd0, i_push(16'd5));
        wr(8'd1, I_NEG);
        wr(8'd2, I_HALT);
        do_start();
        wait_end(20);
        chk("neg_result", result, 16'hFFFB);

        // 0x100 * 0x100 truncates to 0
        do_reset();
        wr(8'd0, i_push(16'h0100));
        wr(8'd1, i_push(16'h0100));
        wr(8'd2, I_MUL);
        wr(8'd3, I_HALT);
        do_start();
        wait_end(20);
        chk("mul_done", done, 1);
        chk("mul_result", result, 16'h0000);

        // ADD on an empty stack: error, nothing issued, pc held
        do_reset();
        wr(8'd0, I_ADD);
        do_start();
        chk("uf_idle", {busy, push, op, d}, {1'b1, 1'b0, 2'b00, 16'd0});
        @(negedge step);
        chk("uf_err", {busy, done, err}, 3'b001);
        chk("uf_pc", pc, 0);

        // Reset mid-program, then rerun with retained program
        do_reset();
        load_add34();
        do_start();
        @(negedge step);
        chk("mid_pc1", pc, 1);
        #2 nrst = 1'b0;
        #1;
        chk("mid_rst", {busy, done, err, push, op, d, result, pc}, 32'd0);
        @(negedge step);
        nrst = 1'b1;
        do_start();
        wait_end(20);
        chk("mid_rerun", result, 16'd7);

        // Write and start during RUN are ignored
        do_reset();
        do_start();
        @(negedge step);
        prog_we = 1'b1; start = 1'b1; prog_addr = 8'd0; prog_data = i_push(16'd9);
        @(negedge step);
        prog_we = 1'b0; start = 1'b0;
        chk("run_start_ign", pc, 2);
        wait_end(20);
        chk("run_we_r1", result, 16'd7);
        do_reset();
        do_start();
        chk("run_we_word0", d, 16'd3);
        wait_end(20);
        chk("run_we_r2", result, 16'd7);

        // Simultaneous write to address 0 and start: new word is fetched
        do_reset();
        @(negedge step);
        start = 1'b1; prog_we = 1'b1; prog_addr = 8'd0; prog_data = i_push(16'd9);
        @(negedge step);
        start = 1'b0; prog_we = 1'b0;
        chk("ws_first", {busy, push, d}, {1'b1, 1'b1, 16'd9});
        wait_end(20);
        chk("ws_result", result, 16'd13);

        // End of memory: PUSH then 255 NOPs, no HALT
        do_reset();
        wr(8'd0, i_push(16'h1234));
        for (int a = 1; a < 256; a++) wr(a[7:0], I_NOP);
        do_start();
        wait_end(300);
        chk("eom_state", {busy, done, err}, 3'b010);
        chk("eom_pc", pc, 255);
        chk("eom_pre", result, 16'h0000);
        @(negedge step);
        chk("eom_result", result, 16'h1234);
        chk("eom_pc_hold", pc, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
